vram_sys_arb: RTL and testbench

- Arbitrates the single vram system-clock port between two requesters: Earthrise (draw engine) and the CPU.
- Sits between the requesters and vram's addr_sys/wmask_sys/din_sys/dout_sys port, replacing the direct Earthrise-to-vram connection.
- Grants one transaction per cycle using round-robin arbitration, registers the winning request onto vram, and routes read data back to the requester that issued the read.
- Read data is aligned using a latency-tag pipeline.

---
 rtl/vram_sys_arb.sv | 113 +++++++++++
 tb/tb_vram_sys_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_sys_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | vram_sys_arb: round-robin arbiter for the vram system-clock port,    |
// | shared by Earthrise and the CPU, with latency-tagged read return.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vram_sys_arb #(
  parameter int WORD     = 32,
  parameter int ADDRW    = 14,
  parameter int VRAM_LAT = 2
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             er_req,
  input  logic [ADDRW-1:0] er_addr,
  input  logic [WORD-1:0]  er_wmask,
  input  logic [WORD-1:0]  er_din,
  output logic             er_gnt,
  output logic [WORD-1:0]  er_rdata,
  output logic             er_rvalid,
  input  logic             cpu_req,
  input  logic [ADDRW-1:0] cpu_addr,
  input  logic [WORD-1:0]  cpu_wmask,
  input  logic [WORD-1:0]  cpu_din,
  output logic             cpu_gnt,
  output logic [WORD-1:0]  cpu_rdata,
  output logic             cpu_rvalid,
  output logic [ADDRW-1:0] vram_addr,
  output logic [WORD-1:0]  vram_wmask,
  output logic [WORD-1:0]  vram_din,
  input  logic [WORD-1:0]  vram_dout,
  output logic             busy
);

  localparam int STAGES = VRAM_LAT + 1;

  logic             favour_er_q, favour_er_d;
  logic             any_gnt;
  logic             rd_gnt;
  logic [ADDRW-1:0] win_addr;
  logic [WORD-1:0]  win_wmask;
  logic [WORD-1:0]  win_din;

  logic [ADDRW-1:0] vram_addr_q,  vram_addr_d;
  logic [WORD-1:0]  vram_wmask_q, vram_wmask_d;
  logic [WORD-1:0]  vram_din_q,   vram_din_d;

  // Tag pipeline: one {valid, owner} pair per stage; owner=1 means Earthrise.
  logic [STAGES-1:0] tag_vld_q, tag_vld_d;
  logic [STAGES-1:0] tag_own_q, tag_own_d;

  always_comb begin
    er_gnt  = er_req  & (~cpu_req | favour_er_q);
    cpu_gnt = cpu_req & (~er_req  | ~favour_er_q);
    any_gnt = er_gnt | cpu_gnt;

    win_addr  = er_gnt ? er_addr  : cpu_addr;
    win_wmask = er_gnt ? er_wmask : cpu_wmask;
    win_din   = er_gnt ? er_din   : cpu_din;
    rd_gnt    = any_gnt & (win_wmask == '0);

    favour_er_d = any_gnt ? cpu_gnt : favour_er_q;
  end

  // Idle cycles must never leave a stale mask on vram, so mask/data drop to 0.
  always_comb begin
    vram_addr_d  = vram_addr_q;
    vram_wmask_d = '0;
    vram_din_d   = '0;
    if (any_gnt) begin
      vram_addr_d  = win_addr;
      vram_wmask_d = win_wmask;
      vram_din_d   = win_din;
    end
  end

  always_comb begin
    tag_vld_d = {tag_vld_q[STAGES-2:0], rd_gnt};
    tag_own_d = {tag_own_q[STAGES-2:0], er_gnt};
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      favour_er_q  <= 1'b0;
      vram_addr_q  <= '0;
      vram_wmask_q <= '0;
      vram_din_q   <= '0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
    end else begin
      favour_er_q  <= favour_er_d;
      vram_addr_q  <= vram_addr_d;
      vram_wmask_q <= vram_wmask_d;
      vram_din_q   <= vram_din_d;
      tag_vld_q    <= tag_vld_d;
      tag_own_q    <= tag_own_d;
    end
  end

  always_comb begin
    vram_addr  = vram_addr_q;
    vram_wmask = vram_wmask_q;
    vram_din   = vram_din_q;
    er_rvalid  = tag_vld_q[STAGES-1] &  tag_own_q[STAGES-1];
    cpu_rvalid = tag_vld_q[STAGES-1] & ~tag_own_q[STAGES-1];
    er_rdata   = vram_dout;
    cpu_rdata  = vram_dout;
    busy       = |tag_vld_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_sys_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vram_sys_arb: directed bench for vram_sys_arb with a 2-cycle      |
// | vram model. Rev 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_vram_sys_arb;

  localparam int WORD  = 32;
  localparam int ADDRW = 14;

  logic             clk_sys = 1'b0;
  logic             rst_sys;
  logic             er_req,  cpu_req;
  logic [ADDRW-1:0] er_addr, cpu_addr;
  logic [WORD-1:0]  er_wmask, er_din, cpu_wmask, cpu_din;
  logic             er_gnt, er_rvalid, cpu_gnt, cpu_rvalid, busy;
  logic [WORD-1:0]  er_rdata, cpu_rdata;
  logic [ADDRW-1:0] vram_addr;
  logic [WORD-1:0]  vram_wmask, vram_din, vram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  vram_sys_arb #(.WORD(WORD), .ADDRW(ADDRW), .VRAM_LAT(2)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .er_req(er_req), .er_addr(er_addr), .er_wmask(er_wmask), .er_din(er_din),
    .er_gnt(er_gnt), .er_rdata(er_rdata), .er_rvalid(er_rvalid),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wmask(cpu_wmask), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .vram_addr(vram_addr), .vram_wmask(vram_wmask), .vram_din(vram_din),
    .vram_dout(vram_dout), .busy(busy)
  );

  // vram model: word i powers up as 0xC0DE0000|i; dout valid 2 edges after addr.
  logic [WORD-1:0] mem [0:1023];
  logic [9:0]      a1;
  logic            mem_ready = 1'b0;

  always @(posedge clk_sys) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | i;
      mem_ready <= 1'b1;
    end else if (vram_wmask != '0) begin
      mem[vram_addr[9:0]] <= (mem[vram_addr[9:0]] & ~vram_wmask) | (vram_din & vram_wmask);
    end
    a1        <= vram_addr[9:0];
    vram_dout <= mem[a1];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, return at the following negedge.
  task automatic drive(input logic rst,
                       input logic e_r, input logic [ADDRW-1:0] e_a,
                       input logic [WORD-1:0] e_m, input logic [WORD-1:0] e_d,
                       input logic c_r, input logic [ADDRW-1:0] c_a,
                       input logic [WORD-1:0] c_m, input logic [WORD-1:0] c_d);
    @(posedge clk_sys);
    #1;
    rst_sys = rst;
    er_req  = e_r; er_addr  = e_a; er_wmask  = e_m; er_din  = e_d;
    cpu_req = c_r; cpu_addr = c_a; cpu_wmask = c_m; cpu_din = c_d;
    @(negedge clk_sys);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  int er_cnt, cpu_cnt, j;

  initial begin
    rst_sys = 1'b1;
    er_req = 0; er_addr = '0; er_wmask = '0; er_din = '0;
    cpu_req = 0; cpu_addr = '0; cpu_wmask = '0; cpu_din = '0;

    // Reset state
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wmask", vram_wmask, 0);
    chk("rst_din", vram_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", {er_rvalid, cpu_rvalid}, 0);

    // Single CPU read
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 14'h0010, '0, '0);
    chk("t1_gnt", {er_gnt, cpu_gnt}, 2'b01);
    idle();
    chk("t1_addr", vram_addr, 14'h0010);
    chk("t1_wmask", vram_wmask, 0);
    chk("t1_busy", busy, 1);
    idle();
    chk("t1_rv_early", {er_rvalid, cpu_rvalid}, 0);
    idle();
    chk("t1_rv", {er_rvalid, cpu_rvalid}, 2'b01);
    chk("t1_rdata", cpu_rdata, 32'hC0DE_0010);
    idle();
    chk("t1_rv_after", {er_rvalid, cpu_rvalid}, 0);
    chk("t1_busy_end", busy, 0);

    // Continuous contention after reset: CPU first, then strict alternation
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    er_cnt = 0; cpu_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i < 6), 14'h100 + i/2, '0, '0, (i < 6), 14'h200 + (i+1)/2, '0, '0);
      if (i < 6) chk($sformatf("t2_gnt%0d", i), {er_gnt, cpu_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      er_cnt += er_rvalid; cpu_cnt += cpu_rvalid;
      if (i >= 3 && i <= 8) begin
        j = i - 3;
        if (j % 2 == 0) begin
          chk($sformatf("t2_rv%0d", i), {er_rvalid, cpu_rvalid}, 2'b01);
          chk($sformatf("t2_rd%0d", i), cpu_rdata, 32'hC0DE_0200 + j/2);
        end else begin
          chk($sformatf("t2_rv%0d", i), {er_rvalid, cpu_rvalid}, 2'b10);
          chk($sformatf("t2_rd%0d", i), er_rdata, 32'hC0DE_0100 + (j-1)/2);
        end
      end else begin
        chk($sformatf("t2_rv%0d", i), {er_rvalid, cpu_rvalid}, 0);
      end
    end
    chk("t2_er_cnt", er_cnt, 3);
    chk("t2_cpu_cnt", cpu_cnt, 3);

    // Masked ER write then read-back of the same word
    drive(1'b0, 1'b1, 14'h0005, 32'h0000_FF00, 32'hAAAA_AAAA, 1'b0, '0, '0, '0);
    chk("t3_wgnt", er_gnt, 1);
    drive(1'b0, 1'b1, 14'h0005, '0, '0, 1'b0, '0, '0, '0);
    chk("t3_rgnt", er_gnt, 1);
    chk("t3_waddr", vram_addr, 14'h0005);
    chk("t3_wmask", vram_wmask, 32'h0000_FF00);
    chk("t3_wdin", vram_din, 32'hAAAA_AAAA);
    idle();
    chk("t3_idle_wmask", vram_wmask, 0);
    chk("t3_idle_din", vram_din, 0);
    chk("t3_idle_addr", vram_addr, 14'h0005);
    idle();
    chk("t3_no_wr_rv", {er_rvalid, cpu_rvalid}, 0);
    idle();
    chk("t3_rv", {er_rvalid, cpu_rvalid}, 2'b10);
    chk("t3_rdata", er_rdata, 32'hC0DE_AA05);

    // Idle cycles keep the pointer; last grant was ER so CPU is favoured
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("t4_idle_wm%0d", i), vram_wmask, 0);
      chk($sformatf("t4_idle_gnt%0d", i), {er_gnt, cpu_gnt}, 0);
    end
    drive(1'b0, 1'b1, 14'h0050, '0, '0, 1'b1, 14'h0060, '0, '0);
    chk("t4_gnt0", {er_gnt, cpu_gnt}, 2'b01);
    drive(1'b0, 1'b1, 14'h0050, '0, '0, 1'b1, 14'h0061, '0, '0);
    chk("t4_gnt1", {er_gnt, cpu_gnt}, 2'b10);
    idle();
    chk("t4_wm_a", vram_wmask, 0);
    idle();
    chk("t4_wm_b", vram_wmask, 0);
    drive(1'b0, 1'b1, 14'h0051, '0, '0, 1'b1, 14'h0061, '0, '0);
    chk("t4_gnt2", {er_gnt, cpu_gnt}, 2'b01);
    for (int i = 0; i < 4; i++) idle();

    // Reset with two reads in flight
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 14'h0020, '0, '0);
    chk("t5_gnt0", cpu_gnt, 1);
    drive(1'b0, 1'b1, 14'h0030, '0, '0, 1'b0, '0, '0, '0);
    chk("t5_gnt1", er_gnt, 1);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    chk("t5_busy_pre", busy, 1);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("t5_rv%0d", i), {er_rvalid, cpu_rvalid}, 0);
      chk($sformatf("t5_busy%0d", i), busy, 0);
    end
    chk("t5_wmask", vram_wmask, 0);
    chk("t5_addr", vram_addr, 0);

    // Reset clears a write already registered onto vram
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 14'h0007, 32'hFFFF_FFFF, 32'h1234_5678);
    chk("t5b_gnt", cpu_gnt, 1);
    drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    chk("t5b_wm_pre", vram_wmask, 32'hFFFF_FFFF);
    chk("t5b_din_pre", vram_din, 32'h1234_5678);
    idle();
    chk("t5b_wm_post", vram_wmask, 0);
    chk("t5b_din_post", vram_din, 0);
    chk("t5b_addr_post", vram_addr, 0);
    drive(1'b0, 1'b1, 14'h0008, '0, '0, 1'b1, 14'h0009, '0, '0);
    chk("t5b_ptr_reset", {er_gnt, cpu_gnt}, 2'b01);
    for (int i = 0; i < 4; i++) idle();

    // ER alone for 10 cycles
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, (i < 10), 14'h0040 + i, '0, '0, 1'b0, '0, '0, '0);
      chk($sformatf("t6_gnt%0d", i), {er_gnt, cpu_gnt}, (i < 10) ? 2'b10 : 2'b00);
      chk($sformatf("t6_busy%0d", i), busy, (i >= 1 && i <= 12));
      chk($sformatf("t6_rv%0d", i), {er_rvalid, cpu_rvalid}, (i >= 3 && i <= 12) ? 2'b10 : 2'b00);
      if (i >= 3 && i <= 12) chk($sformatf("t6_rd%0d", i), er_rdata, 32'hC0DE_0040 + (i - 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
